// File: rtl/bitblade_fusion_seq.sv
// Job sequencer for the BitBlade mux-fusion PE array: accepts a precision/length job,
// streams operand beats into the array, drains its pipeline and pulses done.
// Optional performance counters are compiled in with FUSION_SEQ_PERF_EN.
module bitblade_fusion_seq #(
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [3:0]       job_prec,
  input  logic [LEN_W-1:0] job_len,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [3:0]       Precision,
  output logic             pe_en,
  output logic             pe_clr,
  output logic             pe_last,
  output logic             busy,
  output logic             done,
`ifdef FUSION_SEQ_PERF_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      job_cyc,
`endif
  output logic             err
);

  localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_beats;
  logic [DW-1:0]    r_drain;
  logic             r_first;
  logic             r_pe_en, r_pe_clr, r_pe_last;
  logic [3:0]       r_prec;
  logic             r_err;

  logic w_accept, w_prec_ok, w_beat, w_last_beat;

  assign w_prec_ok   = (job_prec[3:2] != 2'b11) && (job_prec[1:0] != 2'b11);
  assign w_accept    = job_valid && (r_state == IDLE);
  assign w_beat      = src_valid && (r_state == RUN);
  assign w_last_beat = w_beat && (r_beats == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = (!w_prec_ok || job_len == '0) ? DONE : RUN;
      RUN:   if (w_last_beat) w_next = DRAIN;
      // DRAIN starts with the final pe_en cycle, then waits DRAIN_CYC more cycles
      DRAIN: if (r_drain == '0) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    job_ready = (r_state == IDLE);
    src_ready = (r_state == RUN);
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beats   <= '0;
      r_drain   <= '0;
      r_first   <= 1'b0;
      r_pe_en   <= 1'b0;
      r_pe_clr  <= 1'b0;
      r_pe_last <= 1'b0;
      r_prec    <= 4'b0000;
      r_err     <= 1'b0;
    end else begin
      r_pe_en   <= w_beat;
      r_pe_clr  <= w_beat && r_first;
      r_pe_last <= w_last_beat;
      if (w_accept) begin
        r_err <= !w_prec_ok;
        if (w_prec_ok) begin
          r_prec  <= job_prec;
          r_beats <= job_len;
          r_first <= 1'b1;
        end
      end
      if (w_beat) begin
        r_beats <= r_beats - LEN_W'(1);
        r_first <= 1'b0;
      end
      if (w_last_beat)
        r_drain <= DW'(DRAIN_CYC);
      else if (r_state == DRAIN && r_drain != '0)
        r_drain <= r_drain - DW'(1);
    end
  end

  assign pe_en     = r_pe_en;
  assign pe_clr    = r_pe_clr;
  assign pe_last   = r_pe_last;
  assign Precision = r_prec;
  assign err       = r_err;

`ifdef FUSION_SEQ_PERF_EN
  logic [15:0] r_stall, r_cyc;

  // job_cyc counts the acceptance cycle itself, then every busy cycle up to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
      r_cyc   <= '0;
    end else if (w_accept) begin
      r_stall <= '0;
      r_cyc   <= 16'd1;
    end else begin
      if (r_state == RUN && !src_valid && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
      if (r_state != IDLE && r_cyc != 16'hFFFF) r_cyc <= r_cyc + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
  assign job_cyc   = r_cyc;
`endif

endmodule

// File: tb/tb_bitblade_fusion_seq.sv
// Directed self-checking bench for bitblade_fusion_seq (default build, DRAIN_CYC=2).
module tb_bitblade_fusion_seq;
  logic       clk = 1'b0;
  logic       rst, job_valid, src_valid;
  logic [3:0] job_prec;
  logic [7:0] job_len;
  logic       job_ready, src_ready, pe_en, pe_clr, pe_last, busy, done, err;
  logic [3:0] Precision;
  int checks = 0;
  int errors = 0;

  bitblade_fusion_seq #(.LEN_W(8), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_prec(job_prec), .job_len(job_len), .src_valid(src_valid), .src_ready(src_ready),
    .Precision(Precision), .pe_en(pe_en), .pe_clr(pe_clr), .pe_last(pe_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".prec"}, 32'(Precision), 32'h0);
    chk({tag, ".pe_en"}, 32'(pe_en), 32'h0);
    chk({tag, ".pe_clr"}, 32'(pe_clr), 32'h0);
    chk({tag, ".pe_last"}, 32'(pe_last), 32'h0);
    chk({tag, ".done"}, 32'(done), 32'h0);
    chk({tag, ".err"}, 32'(err), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".src_ready"}, 32'(src_ready), 32'h0);
    chk({tag, ".job_ready"}, 32'(job_ready), 32'h1);
  endtask

  // Bit i of each vector is the value applied/expected after clock edge i+1.
  task automatic run_seq(input string tag, input int n, input logic [15:0] sv,
                         input logic [15:0] e_pe, input logic [15:0] e_clr,
                         input logic [15:0] e_last, input logic [15:0] e_done,
                         input logic [15:0] e_sr, input logic [15:0] e_busy,
                         input logic [3:0] e_prec);
    for (int i = 0; i < n; i++) begin
      src_valid = sv[i];
      tick();
      chk($sformatf("%s.c%0d.pe_en", tag, i + 1), 32'(pe_en), 32'(e_pe[i]));
      chk($sformatf("%s.c%0d.pe_clr", tag, i + 1), 32'(pe_clr), 32'(e_clr[i]));
      chk($sformatf("%s.c%0d.pe_last", tag, i + 1), 32'(pe_last), 32'(e_last[i]));
      chk($sformatf("%s.c%0d.done", tag, i + 1), 32'(done), 32'(e_done[i]));
      chk($sformatf("%s.c%0d.src_ready", tag, i + 1), 32'(src_ready), 32'(e_sr[i]));
      chk($sformatf("%s.c%0d.busy", tag, i + 1), 32'(busy), 32'(e_busy[i]));
      chk($sformatf("%s.c%0d.prec", tag, i + 1), 32'(Precision), 32'(e_prec));
    end
    src_valid = 1'b0;
  endtask

  task automatic accept(input logic [3:0] p, input logic [7:0] l);
    job_valid = 1'b1;
    job_prec  = p;
    job_len   = l;
    tick();
    job_valid = 1'b0;
  endtask

  initial begin
    logic seen_bad;
    rst = 1'b1; job_valid = 1'b0; src_valid = 1'b0; job_prec = 4'h0; job_len = 8'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_idle_reset("reset");

    // len=4 at 2b/4b, src_valid held high (including through DRAIN where it must be ignored)
    accept(4'b0101, 8'd4);
    chk("t1.acc.src_ready", 32'(src_ready), 32'h1);
    chk("t1.acc.prec", 32'(Precision), 32'h5);
    chk("t1.acc.pe_en", 32'(pe_en), 32'h0);
    chk("t1.acc.job_ready", 32'(job_ready), 32'h0);
    run_seq("t1", 8, 16'h00FF, 16'h000F, 16'h0001, 16'h0008, 16'h0040,
            16'h0007, 16'h007F, 4'b0101);

    // illegal I code: accepted, err set, straight to DONE, Precision kept
    src_valid = 1'b1;
    accept(4'b0011, 8'd4);
    chk("t3.done", 32'(done), 32'h1);
    chk("t3.err", 32'(err), 32'h1);
    chk("t3.prec", 32'(Precision), 32'h5);
    chk("t3.src_ready", 32'(src_ready), 32'h0);
    tick();
    chk("t3.pe_en", 32'(pe_en), 32'h0);
    chk("t3.done_end", 32'(done), 32'h0);
    chk("t3.err_sticky", 32'(err), 32'h1);
    chk("t3.job_ready", 32'(job_ready), 32'h1);
    src_valid = 1'b0;
    tick();
    chk("t3.err_sticky2", 32'(err), 32'h1);

    // len=3 at 8b W, gappy source 1,0,0,1,1
    accept(4'b1000, 8'd3);
    chk("t2.acc.err_clr", 32'(err), 32'h0);
    chk("t2.acc.prec", 32'(Precision), 32'h8);
    run_seq("t2", 9, 16'h0019, 16'h0019, 16'h0001, 16'h0010, 16'h0080,
            16'h000F, 16'h00FF, 4'b1000);

    // len=0 with legal precision
    accept(4'b1010, 8'd0);
    chk("t4.done", 32'(done), 32'h1);
    chk("t4.prec", 32'(Precision), 32'hA);
    chk("t4.pe_en", 32'(pe_en), 32'h0);
    chk("t4.busy", 32'(busy), 32'h1);
    tick();
    chk("t4.done_end", 32'(done), 32'h0);
    chk("t4.pe_en2", 32'(pe_en), 32'h0);
    chk("t4.job_ready", 32'(job_ready), 32'h1);

    // reset on beat 2 of a len=5 job
    accept(4'b0101, 8'd5);
    src_valid = 1'b1;
    tick();
    chk("t5.b1.pe_en", 32'(pe_en), 32'h1);
    chk("t5.b1.pe_clr", 32'(pe_clr), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    src_valid = 1'b0;
    chk_idle_reset("t5.rst");
    seen_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pe_last || done || pe_en) seen_bad = 1'b1;
    end
    chk("t5.no_last_done", 32'(seen_bad), 32'h0);

    // fresh len=1 job after the abort: pe_clr and pe_last coincide
    accept(4'b0000, 8'd1);
    chk("t6.acc.src_ready", 32'(src_ready), 32'h1);
    run_seq("t6", 5, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0008,
            16'h0000, 16'h000F, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
